mul8_pass_sequencer: RTL and testbench
======================================

Name: mul8_pass_sequencer

Overview:
- Computes an unsigned 8x8 -> 16-bit product by time-sharing one combinational 4x4 array multiplier across four partial-product passes.
- Provides a valid/ready handshake on input and output, so it can sit between an operand source and a result consumer.
- Owns all sequencing of the shared 4x4 datapath: nibble selection, shift alignment and accumulation.

Parameters:
- None. Widths are fixed: 8-bit operands, 4-bit nibbles, 16-bit product, 4 passes.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a/b are valid.
- in_ready  output  1  block can accept operands.
- a  input  8  multiplicand, unsigned.
- b  input  8  multiplier, unsigned.
- out_valid  output  1  product is valid.
- out_ready  input  1  consumer accepts the product.
- product  output  16  unsigned a*b.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high; ports are named clk and rst.
- Reset values: state=IDLE, pass counter=0, accumulator=0, latched operands=0, out_valid=0, product=0, busy=0. in_ready is forced to 0 while rst is high.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a and b, clear the accumulator, set pass=0, go to PASS.
  - PASS: one pass per cycle, pass 0..3. After pass 3 is accumulated, go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- Pass schedule (aL/aH = a[3:0]/a[7:4], same for b):
  - pass 0: aL*bL, shift 0
  - pass 1: aH*bL, shift 4
  - pass 2: aL*bH, shift 4
  - pass 3: aH*bH, shift 8
- Arithmetic: each 8-bit partial product is zero-extended to 16 bits, shifted, and added to the 16-bit accumulator. Overflow is impossible because the maximum result is 255*255=0xFE01.
- Latency: out_valid rises on the 4th rising edge after the accepting edge.
- Throughput: with in_valid and out_ready held high, one result every 6 cycles.
- product is registered and equals the accumulator. It stays stable from out_valid rising until the out_ready handshake completes, and holds its last value afterwards.
- Backpressure: while out_ready is low, remain in DONE with product and out_valid stable; in_ready stays 0.
- in_valid outside IDLE is ignored. Operands are not sampled; the source must hold them until in_ready.
- Operand changes after acceptance have no effect on the computation in flight.
- out_ready high before out_valid has no effect.
- Zero operands are not special-cased: all 4 passes run and product=0.
- Reset mid-operation: the operation is aborted immediately and the block returns to IDLE. No out_valid is produced for the aborted operation.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Decomposition:
- Shared package contains:
  - state enum {IDLE, PASS, DONE}
  - NIB_W=4, OP_W=8, PROD_W=16, NUM_PASSES=4
  - pass shift table {0,4,4,8}
- One sub-module, mul4x4_array: a purely combinational 4x4 unsigned array multiplier built from an AND-gate partial-product matrix and a full-adder ripple array, 8-bit result. It is instantiated exactly once; the sequencer muxes nibbles into it.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> out_valid, busy, product go to 0 immediately; in_ready=0 during reset and 1 the cycle after release.
- Max operands: a=0xFF, b=0xFF, out_ready=1 -> product=0xFE01, out_valid on the 4th edge after accept, high for 1 cycle.
- Mixed nibbles: a=0x12, b=0x34 -> product=0x03A8. Also check a=0x00, b=0xC3 -> product=0x0000 after the full 4-pass latency.
- Backpressure:
  - Stimulus: a=0x0F, b=0x0F with out_ready=0 for 10 cycles, while a second request a=0x01, b=0x01 is driven on in_valid.
  - Required: product=0x00E1 stable, in_ready=0, second request not accepted.
  - After out_ready=1, the second request is accepted and yields 0x0001.
- Reset mid-operation: rst during pass 2 of a=0xAA, b=0x55 -> no out_valid, busy=0. Next op a=0x0F, b=0x10 -> 0x00F0.
- Back-to-back with in_valid and out_ready held high: 0x80*0x02 then 0xA5*0x5A -> 0x0100 then 0x3A02, in order, out_valid pulses 6 cycles apart.

Source files
------------

// File: rtl/mul8_pass_sequencer_pkg.sv
// Shared types and constants for the four-pass 8x8 multiplier sequencer.
// The shift table gives the alignment of each nibble partial product.
package mul8_pass_sequencer_pkg;

   localparam int NIB_W      = 4;
   localparam int OP_W       = 8;
   localparam int PROD_W     = 16;
   localparam int NUM_PASSES = 4;

   localparam int PASS_SHIFT [NUM_PASSES] = '{0, 4, 4, 8};

   typedef enum logic [1:0] {
      IDLE,
      PASS,
      DONE
   } state_t;

endpackage

// File: rtl/mul8_pass_sequencer_mul4x4_array.sv
// Combinational 4x4 unsigned array multiplier: AND-gate partial products
// reduced by rows of ripple full adders, 8-bit result.
module mul4x4_array (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] p
);

   logic [3:0][3:0] pp;
   logic [3:0]      upper;
   logic [3:0]      row_sum;
   logic            carry;

   // Each row adds the next shifted partial product to the upper bits of the
   // running sum; the low bit of every row drops out as a finished product bit.
   always_comb begin
      pp      = '0;
      upper   = '0;
      row_sum = '0;
      carry   = 1'b0;
      p       = '0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            pp[i][j] = a[j] & b[i];
         end
      end
      p[0]  = pp[0][0];
      upper = {1'b0, pp[0][3:1]};
      for (int i = 1; i < 4; i++) begin
         carry = 1'b0;
         for (int j = 0; j < 4; j++) begin
            row_sum[j] = pp[i][j] ^ upper[j] ^ carry;
            carry      = (pp[i][j] & upper[j]) | (carry & (pp[i][j] ^ upper[j]));
         end
         p[i]  = row_sum[0];
         upper = {carry, row_sum[3:1]};
      end
      p[7:4] = upper;
   end

endmodule

// File: rtl/mul8_pass_sequencer.sv
// Unsigned 8x8 multiplier that time-shares one 4x4 array multiplier over
// four passes, with valid/ready handshakes on operands and product.
module mul8_pass_sequencer
   import mul8_pass_sequencer_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   a,
   input  logic [OP_W-1:0]   b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PROD_W-1:0] product,
   output logic              busy
);

   state_t              state;
   state_t              state_next;
   logic [1:0]          pass_cnt;
   logic [OP_W-1:0]     a_q;
   logic [OP_W-1:0]     b_q;
   logic [PROD_W-1:0]   acc;
   logic [PROD_W-1:0]   acc_sum;
   logic [NIB_W-1:0]    nib_a;
   logic [NIB_W-1:0]    nib_b;
   logic [2*NIB_W-1:0]  partial;
   logic                accept;
   logic                last_pass;

   assign in_ready  = (state == IDLE) && !rst;
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign last_pass = (pass_cnt == 2'(NUM_PASSES - 1));

   // Pass bit 0 picks the high nibble of a, bit 1 the high nibble of b,
   // which walks aL*bL, aH*bL, aL*bH, aH*bH in order.
   assign nib_a   = pass_cnt[0] ? a_q[7:4] : a_q[3:0];
   assign nib_b   = pass_cnt[1] ? b_q[7:4] : b_q[3:0];
   assign acc_sum = acc + ({8'b0, partial} << PASS_SHIFT[pass_cnt]);

   mul4x4_array u_mul (
      .a (nib_a),
      .b (nib_b),
      .p (partial)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept)    state_next = PASS;
         PASS:    if (last_pass) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   // Product is captured from the final sum so it survives the accumulator
   // being cleared by the next accepted operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pass_cnt <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc      <= '0;
         product  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_q      <= a;
                  b_q      <= b;
                  acc      <= '0;
                  pass_cnt <= '0;
               end
            end
            PASS: begin
               acc      <= acc_sum;
               pass_cnt <= pass_cnt + 2'd1;
               if (last_pass) begin
                  product <= acc_sum;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul8_pass_sequencer.sv
// Scoreboard bench for mul8_pass_sequencer: directed cases from the test plan
// followed by random operands with random output backpressure.
module tb_mul8_pass_sequencer;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] product;
   logic        busy;

   int          cycle       = 0;
   int          check_count = 0;
   int          pass_count  = 0;
   int          last_hs     = 0;
   int          prev_hs     = 0;
   bit          rand_en     = 0;
   logic [15:0] exp_q [$];

   mul8_pass_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      check_count++;
      if (actual === expected) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
      end
   endtask

   // Holds operands until accepted, recording the reference product a*b and
   // the edge that accepted them; returns on the negedge after acceptance.
   task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tb_val,
                                output int acc_edge);
      bit done;
      done     = 0;
      acc_edge = 0;
      a        = ta;
      b        = tb_val;
      in_valid = 1'b1;
      for (int k = 0; k < 300 && !done; k++) begin
         if (in_ready) begin
            exp_q.push_back(16'(ta) * 16'(tb_val));
            acc_edge = cycle + 1;
            done     = 1;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic waitValid(output int rise_cycle);
      bit seen;
      seen       = 0;
      rise_cycle = 0;
      for (int k = 0; k < 300 && !seen; k++) begin
         if (out_valid) begin
            seen       = 1;
            rise_cycle = cycle;
         end else begin
            @(negedge clk);
         end
      end
      if (!seen) checkOutput("valid_timeout", 32'd0, 32'd1);
   endtask

   // Monitor: compares every completed output handshake against the queue.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_result", {16'd0, product}, 32'hFFFF_FFFF);
            end else begin
               checkOutput("scoreboard_product", {16'd0, product}, {16'd0, exp_q.pop_front()});
            end
            prev_hs = last_hs;
            last_hs = cycle;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rand_en) out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      int  ae;
      int  ae2;
      int  rc;
      bit  stable_ok;
      bit  any_valid;

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;

      repeat (2) @(negedge clk);
      checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_product", {16'd0, product}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

      // Max operands, latency and single-cycle valid pulse
      out_ready = 1'b1;
      applyStimulus(8'hFF, 8'hFF, ae);
      waitValid(rc);
      checkOutput("max_latency", rc - ae, 32'd4);
      checkOutput("max_product", {16'd0, product}, 32'h0000_FE01);
      @(negedge clk);
      checkOutput("max_valid_one_cycle", {31'd0, out_valid}, 32'd0);

      // Mixed nibbles and zero operand
      applyStimulus(8'h12, 8'h34, ae);
      waitValid(rc);
      checkOutput("mixed_product", {16'd0, product}, 32'h0000_03A8);
      @(negedge clk);
      applyStimulus(8'h00, 8'hC3, ae);
      waitValid(rc);
      checkOutput("zero_latency", rc - ae, 32'd4);
      checkOutput("zero_product", {16'd0, product}, 32'd0);
      @(negedge clk);

      // Backpressure with a competing request held on in_valid
      out_ready = 1'b0;
      applyStimulus(8'h0F, 8'h0F, ae);
      waitValid(rc);
      a         = 8'h01;
      b         = 8'h01;
      in_valid  = 1'b1;
      stable_ok = 1;
      for (int k = 0; k < 10; k++) begin
         if (product !== 16'h00E1 || out_valid !== 1'b1 || in_ready !== 1'b0) stable_ok = 0;
         @(negedge clk);
      end
      checkOutput("bp_stable", {31'd0, stable_ok}, 32'd1);
      checkOutput("bp_product", {16'd0, product}, 32'h0000_00E1);
      checkOutput("bp_queue_depth", exp_q.size(), 32'd1);
      out_ready = 1'b1;
      applyStimulus(8'h01, 8'h01, ae);
      waitValid(rc);
      checkOutput("bp_second_product", {16'd0, product}, 32'h0000_0001);
      @(negedge clk);

      // Reset during pass 2 aborts the operation
      applyStimulus(8'hAA, 8'h55, ae);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("abort_out_valid", {31'd0, out_valid}, 32'd0);
      checkOutput("abort_busy", {31'd0, busy}, 32'd0);
      checkOutput("abort_product", {16'd0, product}, 32'd0);
      checkOutput("abort_in_ready", {31'd0, in_ready}, 32'd0);
      void'(exp_q.pop_back());
      @(negedge clk);
      rst       = 1'b0;
      any_valid = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (out_valid) any_valid = 1;
      end
      checkOutput("abort_no_valid", {31'd0, any_valid}, 32'd0);
      applyStimulus(8'h0F, 8'h10, ae);
      waitValid(rc);
      checkOutput("after_abort_product", {16'd0, product}, 32'h0000_00F0);
      @(negedge clk);

      // Back-to-back throughput
      applyStimulus(8'h80, 8'h02, ae);
      applyStimulus(8'hA5, 8'h5A, ae2);
      checkOutput("b2b_accept_spacing", ae2 - ae, 32'd6);
      waitValid(rc);
      checkOutput("b2b_latency", rc - ae2, 32'd4);
      checkOutput("b2b_product", {16'd0, product}, 32'h0000_3A02);
      @(negedge clk);
      checkOutput("b2b_valid_spacing", last_hs - prev_hs, 32'd6);

      // Random operands with random backpressure
      rand_en = 1;
      for (int n = 0; n < 24; n++) begin
         applyStimulus(8'($urandom), 8'($urandom), ae);
      end
      rand_en   = 0;
      out_ready = 1'b1;
      for (int k = 0; k < 300 && (exp_q.size() != 0 || busy); k++) @(negedge clk);
      checkOutput("drain_queue_empty", exp_q.size(), 32'd0);
      checkOutput("drain_idle", {31'd0, busy}, 32'd0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
